text_buf_ctrl: RTL

Owns the 256-entry character-code buffer that feeds the text-overlay drawing stage. The drawing stage issues char_xy, and this block returns the stored code one cycle later for the font ROM. Two write requesters (R0: UART text path, R1: game/status logic) share the single write port through round-robin arbitration with valid/ready handshakes. A clear sequencer fills the whole buffer with a fill character on command.

---
 rtl/text_buf_ctrl_pkg.sv | 19 +
 rtl/text_buf_ram.sv | 29 ++
 rtl/text_buf_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/text_buf_ctrl_pkg.sv
// Shared constants and types for the text-overlay character buffer.
package text_buf_ctrl_pkg;

  localparam int TEXT_ADDR_W = 8;
  localparam int TEXT_DATA_W = 7;
  localparam logic [TEXT_DATA_W-1:0] FILL_CHAR_SPACE = 7'h20;

  // Text window geometry: 32 columns x 8 rows of 8x16 character cells.
  localparam int TEXT_COLS   = 32;
  localparam int TEXT_ROWS   = 8;
  localparam int TEXT_CELL_W = 8;
  localparam int TEXT_CELL_H = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } buf_state_t;

endpackage

// File: rtl/text_buf_ram.sv
// Simple dual-port character RAM: one sync write port, one registered
// read-first read port. Contents are never reset; only the output register is.
module text_buf_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 7
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  // Storage write; no reset so the array maps onto block/distributed RAM.
  always_ff @(posedge pclk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read; sees the pre-write value on a same-address collision.
  always_ff @(posedge pclk) begin
    if (rst) o_rdata <= '0;
    else     o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/text_buf_ctrl.sv
// Character buffer controller for the text overlay: display read port,
// round-robin arbitration of two writers, and a buffer-clear sequencer.
// Optional build macro TEXT_BUF_WR_VBLANK_ONLY_EN restricts writes and the
// clear sequence to vertical blanking.
module text_buf_ctrl
  import text_buf_ctrl_pkg::*;
#(
  parameter int                ADDR_W    = TEXT_ADDR_W,
  parameter int                DATA_W    = TEXT_DATA_W,
  parameter logic [DATA_W-1:0] FILL_CHAR = FILL_CHAR_SPACE
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] char_xy,
  output logic [DATA_W-1:0] char_code,
  input  logic              vblank,
  input  logic              r0_valid,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_data,
  output logic              r0_ready,
  input  logic              r1_valid,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_data,
  output logic              r1_ready,
  input  logic              clr_req,
  output logic              clr_busy
);

  buf_state_t        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_last_grant;  // 0: R0 won last, 1: R1 won last
  logic              r_clr_busy;
  logic              w_gate;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;

`ifdef TEXT_BUF_WR_VBLANK_ONLY_EN
  // Buffer changes only while the display is blanked, so no frame tears.
  assign w_gate = vblank;
`else
  logic w_unused_vblank;
  assign w_unused_vblank = vblank;
  assign w_gate          = 1'b1;
`endif

  // Next state, ready generation and write-port mux.
  always_comb begin
    w_state_nxt = r_state;
    r0_ready    = 1'b0;
    r1_ready    = 1'b0;
    w_we        = 1'b0;
    w_waddr     = r_cnt;
    w_wdata     = FILL_CHAR;
    case (r_state)
      ST_IDLE: begin
        if (clr_req) begin
          w_state_nxt = ST_CLEAR;
        end else if (w_gate) begin
          // On contention the requester that did not win last time goes.
          r0_ready = r0_valid & (~r1_valid | r_last_grant);
          r1_ready = r1_valid & (~r0_valid | ~r_last_grant);
          if (r0_ready) begin
            w_we    = 1'b1;
            w_waddr = r0_addr;
            w_wdata = r0_data;
          end else if (r1_ready) begin
            w_we    = 1'b1;
            w_waddr = r1_addr;
            w_wdata = r1_data;
          end
        end
      end
      ST_CLEAR: begin
        if (w_gate) begin
          // A reset aborting the clear must not fill the entry at cnt.
          w_we = ~rst;
          if (r_cnt == {ADDR_W{1'b1}}) w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state, clear counter, busy flag and round-robin history.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_clr_busy   <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_busy <= (w_state_nxt == ST_CLEAR);
      // Counter wraps to 0 on the last entry, ready for the next clear.
      if (r_state == ST_CLEAR && w_gate) r_cnt <= r_cnt + ADDR_W'(1);
      if (r0_ready)      r_last_grant <= 1'b0;
      else if (r1_ready) r_last_grant <= 1'b1;
    end
  end

  assign clr_busy = r_clr_busy;

  text_buf_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .pclk    (pclk),
    .rst     (rst),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (char_xy),
    .o_rdata (char_code)
  );

endmodule
